operation_control_word_2: RTL and testbench
===========================================

// Module: operation_control_word_2
// PURPOSE
//  8259A OCW2 command decoder inside the control-logic block.
//  - Decodes OCW2 writes (R/SL/EOI = D7..D5) into a one-cycle end_of_interrupt mask for the ISR.
//  - Tracks rotate-in-AEOI mode and the rotating-priority base.
//  - Issues the automatic EOI at the end of an INTA sequence when AEOI is configured.
// PARAMETERS
//  PRIORITY_INIT  3'd7  priority_rotate value after reset/ICW1 (IR0 highest priority)
// PORTS
//  clock                           in   1  system clock; all state on rising edge
//  reset_n                         in   1  asynchronous, active-low reset
//  write_initial_command_word_1    in   1  ICW1 write strobe; re-initialises block
//  auto_eoi_config                 in   1  ICW4 AEOI bit (latched elsewhere)
//  end_of_acknowledge_sequence     in   1  last INTA pulse of the acknowledge cycle
//  acknowledge_interrupt           in   8  one-hot IR being acknowledged
//  write_operation_control_word_2  in   1  OCW2 write strobe
//  internal_data_bus               in   8  OCW2 byte: D7=R D6=SL D5=EOI D2..0=L
//  highest_level_in_service        in   8  one-hot highest-priority ISR bit
//  num2bit                         in   3  IR level number for specific EOI
//  bit2num                         in   8  one-hot level for rotate-on-nonspecific EOI
//  end_of_interrupt                out  8  ISR clear mask (combinational)
//  auto_rotate_mode                out  1  rotate-in-AEOI enabled (registered)
//  priority_rotate                 out  3  lowest-priority IR number (registered)
// BEHAVIOUR
//  Reset (async, reset_n=0): auto_rotate_mode=0, priority_rotate=PRIORITY_INIT.
//  - end_of_interrupt is combinational and reads 0 under reset.
//  end_of_interrupt (combinational; 0 when idle):
//  - ICW1 write -> 8'hFF; overrides everything else.
//  - Otherwise: bitwise OR of the OCW2 term and the AEOI term.
//  - OCW2 term (write strobe high):
//    - D7..5 = 001 or 101 -> highest_level_in_service.
//    - D7..5 = 011 or 111 -> 1<<num2bit.
//    - All other codes -> 0.
//  - AEOI term: auto_eoi_config & end_of_acknowledge_sequence -> acknowledge_interrupt.
//  Registered state (rising clock edge; priority top-down):
//  - ICW1 write: auto_rotate_mode<=0; priority_rotate<=PRIORITY_INIT.
//  - OCW2 write, by D7..5:
//    - 000: auto_rotate_mode<=0.
//    - 100: auto_rotate_mode<=1.
//    - 101: priority_rotate<=enc(bit2num).
//    - 110, 111: priority_rotate<=D2..0.
//    - 001, 010, 011: no state change.
//  - Else if auto_rotate_mode & auto_eoi_config & end_of_acknowledge_sequence:
//    priority_rotate<=enc(acknowledge_interrupt).
//  - enc(x): index of lowest set bit. If x==0, priority_rotate holds its value.
//  - Strobes are level-sensitive. State updates on each clock edge while a strobe is high;
//    repeated updates are idempotent.
//  - Simultaneous OCW2 write and AEOI: EOI masks OR'd; OCW2 state update wins over AEOI rotation.
// CONFIGURATION
//  OCW2_AEOI_ROTATE_EN:
//  - Defined: rotate-in-AEOI commands (000/100) and AEOI rotation behave as above.
//  - Undefined: auto_rotate_mode is constant 0; codes 000/100 have no effect;
//    no AEOI-driven rotation. EOI behaviour is unchanged.
// TESTING
//  - Reset, then ICW1 pulse -> eoi=8'hFF during pulse; priority_rotate=7; auto_rotate_mode=0.
//  - OCW2 0x20, highest_level_in_service=8'h08 -> eoi=8'h08; state unchanged.
//  - OCW2 0x60, num2bit=6 -> eoi=8'h40.
//  - AEOI=1, end_of_acknowledge_sequence=1, ack=8'h01, no OCW2 -> eoi=8'h01.
//    After OCW2 0x80, repeat -> auto_rotate_mode=1; priority_rotate=0.
//  - OCW2 0xA0, ISR=8'h10, bit2num=8'h02 -> eoi=8'h10; next edge priority_rotate=1.
//  - OCW2 0xE3, num2bit=3 -> eoi=8'h08; priority_rotate=3. reset_n low mid-write -> state = reset values.

Source files
------------

// File: rtl/operation_control_word_2.sv
// Purpose     : 8259A OCW2 decoder; builds the ISR end-of-interrupt mask, tracks rotate-in-AEOI and the rotating-priority base.
// Latency     : end_of_interrupt is combinational (same cycle); auto_rotate_mode/priority_rotate update on the next rising clock edge.
// Backpressure: none; strobes are level-sensitive and are never stalled.
//
// Ports:
//   clock, reset_n                  clock and asynchronous active-low reset
//   write_initial_command_word_1    ICW1 strobe; re-initialises the block
//   auto_eoi_config                 ICW4 AEOI bit
//   end_of_acknowledge_sequence     last INTA pulse of an acknowledge cycle
//   acknowledge_interrupt[7:0]      one-hot IR being acknowledged
//   write_operation_control_word_2  OCW2 strobe
//   internal_data_bus[7:0]          OCW2 byte: D7=R, D6=SL, D5=EOI, D2..0=L
//   highest_level_in_service[7:0]   one-hot highest-priority in-service bit
//   num2bit[2:0]                    level number for specific EOI
//   bit2num[7:0]                    one-hot level for rotate-on-nonspecific EOI
//   end_of_interrupt[7:0]           ISR clear mask (combinational)
//   auto_rotate_mode                rotate-in-AEOI enabled (registered)
//   priority_rotate[2:0]            lowest-priority IR number (registered)
//
// Build option: OCW2_AEOI_ROTATE_EN enables rotate-in-AEOI commands (R/SL/EOI = 000 / 100)
// and the automatic rotation on AEOI. Without it auto_rotate_mode is tied low.

module operation_control_word_2 #(
  parameter logic [2:0] PRIORITY_INIT = 3'd7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       write_initial_command_word_1,
  input  logic       auto_eoi_config,
  input  logic       end_of_acknowledge_sequence,
  input  logic [7:0] acknowledge_interrupt,
  input  logic       write_operation_control_word_2,
  input  logic [7:0] internal_data_bus,
  input  logic [7:0] highest_level_in_service,
  input  logic [2:0] num2bit,
  input  logic [7:0] bit2num,
  output logic [7:0] end_of_interrupt,
  output logic       auto_rotate_mode,
  output logic [2:0] priority_rotate
);

  // R/SL/EOI command codes
  localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI       = 3'b001;
  localparam logic [2:0] CMD_S_EOI        = 3'b011;
  localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] CMD_SET_PRIO     = 3'b110;
  localparam logic [2:0] CMD_ROT_S_EOI    = 3'b111;

  // Index of the lowest set bit; callers guard against an all-zero input.
  function automatic logic [2:0] lowest_bit(input logic [7:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (x[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [2:0] ocw2_cmd;
  logic       aeoi_event;
  logic [7:0] ocw2_eoi;
  logic [7:0] aeoi_eoi;

  logic       auto_rotate_mode_q, auto_rotate_mode_d;
  logic [2:0] priority_rotate_q,  priority_rotate_d;

  assign ocw2_cmd   = internal_data_bus[7:5];
  assign aeoi_event = auto_eoi_config & end_of_acknowledge_sequence;

  // ISR clear mask
  always_comb begin
    ocw2_eoi = 8'h00;
    if (write_operation_control_word_2) begin
      case (ocw2_cmd)
        CMD_NS_EOI, CMD_ROT_NS_EOI: ocw2_eoi = highest_level_in_service;
        CMD_S_EOI,  CMD_ROT_S_EOI:  ocw2_eoi = 8'h01 << num2bit;
        default:                    ocw2_eoi = 8'h00;
      endcase
    end

    aeoi_eoi = aeoi_event ? acknowledge_interrupt : 8'h00;

    // Held at zero during reset so nothing downstream is cleared spuriously.
    if (!reset_n) begin
      end_of_interrupt = 8'h00;
    end else if (write_initial_command_word_1) begin
      end_of_interrupt = 8'hFF;
    end else begin
      end_of_interrupt = ocw2_eoi | aeoi_eoi;
    end
  end

  // Next-state: ICW1 beats OCW2, and any OCW2 write beats AEOI rotation.
  always_comb begin
    auto_rotate_mode_d = auto_rotate_mode_q;
    priority_rotate_d  = priority_rotate_q;

    if (write_initial_command_word_1) begin
      auto_rotate_mode_d = 1'b0;
      priority_rotate_d  = PRIORITY_INIT;
    end else if (write_operation_control_word_2) begin
      case (ocw2_cmd)
`ifdef OCW2_AEOI_ROTATE_EN
        CMD_ROT_AEOI_CLR: auto_rotate_mode_d = 1'b0;
        CMD_ROT_AEOI_SET: auto_rotate_mode_d = 1'b1;
`endif
        CMD_ROT_NS_EOI: begin
          if (bit2num != 8'h00) priority_rotate_d = lowest_bit(bit2num);
        end
        CMD_SET_PRIO, CMD_ROT_S_EOI: priority_rotate_d = internal_data_bus[2:0];
        default: ;
      endcase
    end
`ifdef OCW2_AEOI_ROTATE_EN
    else if (auto_rotate_mode_q && aeoi_event && (acknowledge_interrupt != 8'h00)) begin
      priority_rotate_d = lowest_bit(acknowledge_interrupt);
    end
`endif

`ifndef OCW2_AEOI_ROTATE_EN
    auto_rotate_mode_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_rotate_mode_q <= 1'b0;
      priority_rotate_q  <= PRIORITY_INIT;
    end else begin
      auto_rotate_mode_q <= auto_rotate_mode_d;
      priority_rotate_q  <= priority_rotate_d;
    end
  end

  assign auto_rotate_mode = auto_rotate_mode_q;
  assign priority_rotate  = priority_rotate_q;

endmodule

// File: tb/tb_operation_control_word_2.sv
module tb_operation_control_word_2;

`ifdef OCW2_AEOI_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic       icw1;
  logic       aeoi_cfg;
  logic       eas;
  logic [7:0] ack;
  logic       ocw2;
  logic [7:0] bus;
  logic [7:0] isr_hi;
  logic [2:0] n2b;
  logic [7:0] b2n;
  logic [7:0] eoi;
  logic       arm;
  logic [2:0] prio;

  int errors = 0;
  int checks = 0;

  operation_control_word_2 #(.PRIORITY_INIT(3'd7)) dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .write_initial_command_word_1   (icw1),
    .auto_eoi_config                (aeoi_cfg),
    .end_of_acknowledge_sequence    (eas),
    .acknowledge_interrupt          (ack),
    .write_operation_control_word_2 (ocw2),
    .internal_data_bus              (bus),
    .highest_level_in_service       (isr_hi),
    .num2bit                        (n2b),
    .bit2num                        (b2n),
    .end_of_interrupt               (eoi),
    .auto_rotate_mode               (arm),
    .priority_rotate                (prio)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_arm;
  logic [2:0] m_prio;

  function automatic logic [2:0] first_set(input logic [7:0] x);
    int k;
    k = 0;
    while (k < 7 && !x[k]) k++;
    return 3'(k);
  endfunction

  function automatic logic [7:0] model_eoi();
    logic [7:0] m;
    m = 8'h00;
    if (!reset_n) return 8'h00;
    if (icw1) return 8'hFF;
    if (ocw2 && bus[5]) begin
      // EOI bit set: SL selects specific level, otherwise highest in service
      if (bus[6]) m[n2b] = 1'b1;
      else        m = isr_hi;
    end
    if (aeoi_cfg && eas) m = m | ack;
    return m;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_arm  <= 1'b0;
      m_prio <= 3'd7;
    end else if (icw1) begin
      m_arm  <= 1'b0;
      m_prio <= 3'd7;
    end else if (ocw2) begin
      if (bus[7:5] == 3'b000 && ROT) m_arm <= 1'b0;
      if (bus[7:5] == 3'b100 && ROT) m_arm <= 1'b1;
      if (bus[7:5] == 3'b101 && b2n != 8'h00) m_prio <= first_set(b2n);
      if (bus[7:6] == 2'b11) m_prio <= bus[2:0];
    end else if (ROT && m_arm && aeoi_cfg && eas && ack != 8'h00) begin
      m_prio <= first_set(ack);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  bit run_cmp = 1'b0;
  always @(negedge clock) begin
    if (run_cmp) begin
      chk("model_eoi",  {24'h0, eoi},  {24'h0, model_eoi()});
      chk("model_arm",  {31'h0, arm},  {31'h0, m_arm});
      chk("model_prio", {29'h0, prio}, {29'h0, m_prio});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    icw1 = 0; aeoi_cfg = 0; eas = 0; ack = 0;
    ocw2 = 0; bus = 0; isr_hi = 0; n2b = 0; b2n = 0;
  endtask

  // Drives one cycle of inputs, checks the combinational mask mid-cycle,
  // then checks the registered state just after the edge.
  task automatic cyc(input string name, input logic [7:0] exp_eoi,
                     input logic exp_arm, input logic [2:0] exp_prio);
    @(negedge clock);
    #1;
    chk({name, "_eoi"}, {24'h0, eoi}, {24'h0, exp_eoi});
    @(posedge clock);
    #1;
    idle();
    chk({name, "_arm"},  {31'h0, arm},  {31'h0, exp_arm});
    chk({name, "_prio"}, {29'h0, prio}, {29'h0, exp_prio});
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_arm",  {31'h0, arm},  32'h0);
    chk("rst_prio", {29'h0, prio}, 32'h7);
    icw1 = 1'b1;
    #1;
    chk("rst_eoi_gated", {24'h0, eoi}, 32'h0);
    icw1 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run_cmp = 1'b1;
    @(posedge clock);
    #1;

    // Set-priority to 5, then ICW1 together with a specific EOI: ICW1 wins.
    ocw2 = 1; bus = 8'hC5;
    cyc("setprio5", 8'h00, 1'b0, 3'd5);
    icw1 = 1; ocw2 = 1; bus = 8'h65; n2b = 3'd2;
    cyc("icw1", 8'hFF, 1'b0, 3'd7);

    ocw2 = 1; bus = 8'h20; isr_hi = 8'h08;
    cyc("ns_eoi", 8'h08, 1'b0, 3'd7);

    ocw2 = 1; bus = 8'h60; n2b = 3'd6;
    cyc("s_eoi", 8'h40, 1'b0, 3'd7);

    ocw2 = 1; bus = 8'h40; isr_hi = 8'h08; n2b = 3'd1;
    cyc("nop010", 8'h00, 1'b0, 3'd7);

    aeoi_cfg = 1; eas = 1; ack = 8'h01;
    cyc("aeoi_norot", 8'h01, 1'b0, 3'd7);

    ocw2 = 1; bus = 8'h80;
    cyc("rot_aeoi_set", 8'h00, ROT, 3'd7);

    aeoi_cfg = 1; eas = 1; ack = 8'h01;
    cyc("aeoi_rot", 8'h01, ROT, ROT ? 3'd0 : 3'd7);

    ocw2 = 1; bus = 8'hA0; isr_hi = 8'h10; b2n = 8'h02;
    cyc("rot_ns_eoi", 8'h10, ROT, 3'd1);

    ocw2 = 1; bus = 8'hA0; isr_hi = 8'h00; b2n = 8'h00;
    cyc("rot_ns_zero", 8'h00, ROT, 3'd1);

    // OCW2 and AEOI in the same cycle: masks merge, OCW2 blocks rotation.
    ocw2 = 1; bus = 8'h20; isr_hi = 8'h04; aeoi_cfg = 1; eas = 1; ack = 8'h80;
    cyc("ocw2_and_aeoi", 8'h84, ROT, 3'd1);

    aeoi_cfg = 1; eas = 1; ack = 8'h28;
    cyc("aeoi_lowest", 8'h28, ROT, ROT ? 3'd3 : 3'd1);

    aeoi_cfg = 1; eas = 1; ack = 8'h00;
    cyc("aeoi_ack0", 8'h00, ROT, ROT ? 3'd3 : 3'd1);

    aeoi_cfg = 0; eas = 1; ack = 8'h40;
    cyc("aeoi_cfg_off", 8'h00, ROT, ROT ? 3'd3 : 3'd1);

    ocw2 = 1; bus = 8'h00;
    cyc("rot_aeoi_clr", 8'h00, 1'b0, ROT ? 3'd3 : 3'd1);

    aeoi_cfg = 1; eas = 1; ack = 8'h04;
    cyc("aeoi_after_clr", 8'h04, 1'b0, ROT ? 3'd3 : 3'd1);

    ocw2 = 1; bus = 8'hC6;
    cyc("setprio6", 8'h00, 1'b0, 3'd6);

    // Specific rotate, held across an edge, then reset asserted mid-write.
    ocw2 = 1; bus = 8'hE3; n2b = 3'd3;
    @(negedge clock);
    #1;
    chk("rot_s_eoi_eoi", {24'h0, eoi}, 32'h08);
    @(posedge clock);
    #1;
    chk("rot_s_eoi_prio", {29'h0, prio}, 32'h3);
    #1;
    run_cmp = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_eoi",  {24'h0, eoi},  32'h0);
    chk("midrst_arm",  {31'h0, arm},  32'h0);
    chk("midrst_prio", {29'h0, prio}, 32'h7);
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("post_rst_prio", {29'h0, prio}, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
